// File: rtl/reg_wb_queue.sv
// reg_wb_queue: write-back buffer in front of reg_file.
// Register write requests are queued and drained one per cycle into the
// B-port write path of reg_file. Pending values are forwarded to both read
// ports so the core never observes stale register contents.
module reg_wb_queue #(
  parameter int W     = 8,
  parameter int D     = 3,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic [D-1:0]             ReqAddr,
  input  logic [W-1:0]             ReqValue,
  input  logic                     Hold,
  input  logic [D-1:0]             RdAddrA,
  input  logic [D-1:0]             RdAddrB,
  output logic                     RdBValid,
  output logic [1:0]               RegWrite,
  output logic [D-1:0]             srcA,
  output logic [D-1:0]             srcB,
  output logic [W-1:0]             writeValue,
  output logic                     FwdHitA,
  output logic [W-1:0]             FwdValA,
  output logic                     FwdHitB,
  output logic [W-1:0]             FwdValB,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [D-1:0]  addrMem [DEPTH];
  logic [W-1:0]  valMem  [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic          push;
  logic          drain;
  logic [PW-1:0] idx;

  assign Count    = count;
  assign Empty    = (count == '0);
  assign ReqReady = (count != FULL);
  assign push     = ReqValid && ReqReady;
  assign drain    = !Empty && !Hold;
  assign srcA     = RdAddrA;

  // Drive the reg_file B port: write the head entry when draining, else read.
  always_comb begin
    RegWrite   = 2'b00;
    srcB       = RdAddrB;
    writeValue = '0;
    RdBValid   = 1'b1;
    if (drain) begin
      RegWrite   = 2'b10;
      srcB       = addrMem[head];
      writeValue = valMem[head];
      RdBValid   = 1'b0;
    end
  end

  // Pointer, occupancy and storage update; reset discards all pending writes.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        addrMem[tail] <= ReqAddr;
        valMem[tail]  <= ReqValue;
        tail          <= tail + 1'b1;
      end
      if (drain) begin
        head <= head + 1'b1;
      end
      case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Forwarding scan from oldest to youngest; later matches override earlier
  // ones so the youngest pending value wins. The draining head is included.
  always_comb begin
    FwdHitA = 1'b0;
    FwdValA = '0;
    FwdHitB = 1'b0;
    FwdValB = '0;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < count) begin
        if (addrMem[idx] == RdAddrA) begin
          FwdHitA = 1'b1;
          FwdValA = valMem[idx];
        end
        if (addrMem[idx] == RdAddrB) begin
          FwdHitB = 1'b1;
          FwdValB = valMem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Testbench for reg_wb_queue: directed vector table, a reference-FIFO
// stream with pointer wrap and back-pressure, and a reset-discard sequence.
module tb_reg_wb_queue;

  logic       CLK;
  logic       Reset;
  logic       ReqValid;
  logic       ReqReady;
  logic [2:0] ReqAddr;
  logic [7:0] ReqValue;
  logic       Hold;
  logic [2:0] RdAddrA;
  logic [2:0] RdAddrB;
  logic       RdBValid;
  logic [1:0] RegWrite;
  logic [2:0] srcA;
  logic [2:0] srcB;
  logic [7:0] writeValue;
  logic       FwdHitA;
  logic [7:0] FwdValA;
  logic       FwdHitB;
  logic [7:0] FwdValB;
  logic [2:0] Count;
  logic       Empty;

  int nChecks = 0;
  int nErrors = 0;

  reg_wb_queue #(.W(8), .D(3), .DEPTH(4)) dut (
    .CLK(CLK), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqAddr(ReqAddr), .ReqValue(ReqValue), .Hold(Hold),
    .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .RdBValid(RdBValid),
    .RegWrite(RegWrite), .srcA(srcA), .srcB(srcB), .writeValue(writeValue),
    .FwdHitA(FwdHitA), .FwdValA(FwdValA), .FwdHitB(FwdHitB), .FwdValB(FwdValB),
    .Count(Count), .Empty(Empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       hold;
    logic       valid;
    logic [2:0] addr;
    logic [7:0] val;
    logic [2:0] rdA;
    logic [2:0] rdB;
    logic [2:0] eCount;
    logic [1:0] eRW;
    logic [2:0] eSrcB;
    logic [7:0] eWv;
    logic       eRdBV;
    logic       eHitA;
    logic [7:0] eValA;
    logic       eHitB;
    logic [7:0] eValB;
    logic       eReady;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] v;
  } ent_t;
  ent_t model[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            hold  valid addr  val    rdA   rdB  | cnt   RW     srcB  wv     rdBV  hitA  valA   hitB  valB   ready
    vecs[0]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd4, 3'd0, 2'b00, 3'd4, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 1'b1, 3'd2, 8'hAA, 3'd2, 3'd4, 3'd0, 2'b00, 3'd4, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 3'd1, 2'b10, 3'd2, 8'hAA, 1'b0, 1'b1, 8'hAA, 1'b0, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 3'd0, 2'b00, 3'd3, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 3'd1, 8'h11, 3'd1, 3'd1, 3'd0, 2'b00, 3'd1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 3'd3, 8'h33, 3'd1, 3'd3, 3'd1, 2'b00, 3'd3, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 3'd1, 8'h55, 3'd3, 3'd1, 3'd2, 2'b00, 3'd1, 8'h00, 1'b1, 1'b1, 8'h33, 1'b1, 8'h11, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 3'd5, 8'h77, 3'd1, 3'd5, 3'd3, 2'b00, 3'd5, 8'h00, 1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 3'd6, 8'h66, 3'd5, 3'd1, 3'd4, 2'b00, 3'd1, 8'h00, 1'b1, 1'b1, 8'h77, 1'b1, 8'h55, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3'd0, 8'h00, 3'd6, 3'd1, 3'd4, 2'b00, 3'd1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h55, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd3, 3'd4, 2'b10, 3'd1, 8'h11, 1'b0, 1'b1, 8'h55, 1'b1, 8'h33, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 3'd7, 8'h99, 3'd1, 3'd3, 3'd3, 2'b10, 3'd3, 8'h33, 1'b0, 1'b1, 8'h55, 1'b1, 8'h33, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd1, 3'd7, 3'd3, 2'b10, 3'd1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b1, 8'h99, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 3'd2, 8'h22, 3'd1, 3'd5, 3'd2, 2'b10, 3'd5, 8'h77, 1'b0, 1'b0, 8'h00, 1'b1, 8'h77, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd7, 3'd2, 2'b10, 3'd7, 8'h99, 1'b0, 1'b1, 8'h22, 1'b1, 8'h99, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd7, 3'd2, 3'd1, 2'b10, 3'd2, 8'h22, 1'b0, 1'b0, 8'h00, 1'b1, 8'h22, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd0, 3'd0, 2'b00, 3'd0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};

    Reset = 1'b1; ReqValid = 1'b0; ReqAddr = '0; ReqValue = '0;
    Hold = 1'b0; RdAddrA = '0; RdAddrB = '0;
    repeat (2) @(posedge CLK);

    // Directed vector table: outputs checked before the edge that commits the inputs.
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      Reset    = 1'b0;
      Hold     = vecs[i].hold;
      ReqValid = vecs[i].valid;
      ReqAddr  = vecs[i].addr;
      ReqValue = vecs[i].val;
      RdAddrA  = vecs[i].rdA;
      RdAddrB  = vecs[i].rdB;
      #1;
      chk($sformatf("v%0d.Count", i), Count, vecs[i].eCount);
      chk($sformatf("v%0d.Empty", i), Empty, (vecs[i].eCount == 3'd0));
      chk($sformatf("v%0d.ReqReady", i), ReqReady, vecs[i].eReady);
      chk($sformatf("v%0d.RegWrite", i), RegWrite, vecs[i].eRW);
      chk($sformatf("v%0d.srcA", i), srcA, vecs[i].rdA);
      chk($sformatf("v%0d.srcB", i), srcB, vecs[i].eSrcB);
      chk($sformatf("v%0d.writeValue", i), writeValue, vecs[i].eWv);
      chk($sformatf("v%0d.RdBValid", i), RdBValid, vecs[i].eRdBV);
      chk($sformatf("v%0d.FwdHitA", i), FwdHitA, vecs[i].eHitA);
      chk($sformatf("v%0d.FwdValA", i), FwdValA, vecs[i].eValA);
      chk($sformatf("v%0d.FwdHitB", i), FwdHitB, vecs[i].eHitB);
      chk($sformatf("v%0d.FwdValB", i), FwdValB, vecs[i].eValB);
    end

    // 20-request stream against a reference FIFO with periodic Hold back-pressure.
    begin
      int accepted;
      int drained;
      logic expReady;
      logic expDrain;
      accepted = 0;
      drained  = 0;
      model.delete();
      for (int cyc = 0; cyc < 400 && drained < 20; cyc++) begin
        @(negedge CLK);
        Hold     = ((cyc % 8) < 5);
        ReqValid = (accepted < 20);
        ReqAddr  = accepted[2:0];
        ReqValue = 8'(accepted * 13 + 5);
        RdAddrA  = 3'd0;
        RdAddrB  = 3'd1;
        #1;
        expReady = (model.size() != 4);
        expDrain = (model.size() != 0) && !Hold;
        chk($sformatf("s%0d.Count", cyc), Count, model.size());
        chk($sformatf("s%0d.ReqReady", cyc), ReqReady, expReady);
        chk($sformatf("s%0d.RegWrite", cyc), RegWrite, expDrain ? 2'b10 : 2'b00);
        if (expDrain) begin
          chk($sformatf("s%0d.srcB", cyc), srcB, model[0].a);
          chk($sformatf("s%0d.writeValue", cyc), writeValue, model[0].v);
          void'(model.pop_front());
          drained++;
        end
        if (ReqValid && expReady) begin
          model.push_back('{ReqAddr, ReqValue});
          accepted++;
        end
      end
      chk("stream.drained", drained, 20);
    end

    // Reset while entries are pending: nothing may ever be written.
    @(negedge CLK);
    Hold = 1'b1; ReqValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      ReqAddr  = 3'(k + 4);
      ReqValue = 8'(8'hC0 + k);
      @(negedge CLK);
    end
    ReqValid = 1'b0;
    #1;
    chk("rst.preCount", Count, 3);
    @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0; Hold = 1'b0; RdAddrA = 3'd4; RdAddrB = 3'd6;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("r%0d.RegWrite", k), RegWrite, 2'b00);
      chk($sformatf("r%0d.Count", k), Count, 0);
      chk($sformatf("r%0d.ReqReady", k), ReqReady, 1'b1);
      chk($sformatf("r%0d.Empty", k), Empty, 1'b1);
      chk($sformatf("r%0d.FwdHitA", k), FwdHitA, 1'b0);
      chk($sformatf("r%0d.FwdHitB", k), FwdHitB, 1'b0);
      chk($sformatf("r%0d.srcB", k), srcB, 3'd6);
      @(negedge CLK);
    end

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
